// File: rtl/match_round_sequencer.sv
// ---------------------------------------------------------------------------
// match_round_sequencer
//
// Game-flow controller for a best-of-N fighting match. It sits above the
// physics, health and player-input blocks and walks each round through:
//   IDLE -> RRST (round reset pulse) -> CDOWN (pre-fight countdown)
//        -> FIGHT (timed, input enabled) -> REND (result hold)
//        -> RRST for the next round, or MEND when the match is decided.
// All timing advances only on cycles where the one-clk game tick is high.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high; returns to IDLE, all outputs 0
//   tick          one-clk game-tick strobe
//   start_req     level; a rising edge starts a match from IDLE or MEND
//   ko_p1/ko_p2   player health depleted
//   health_p1/p2  health values, used only to decide a time-out
//   round_reset   resets physics/health/bullets while high
//   input_enable  high only while fighting
//   round_num     current round, 1-based; 0 in IDLE
//   p1_wins       rounds won by player 1
//   p2_wins       rounds won by player 2
//   countdown     seconds left in the pre-fight countdown, else 0
//   round_time    seconds left in the fight
//   round_winner  00 none, 01 P1, 10 P2, 11 draw
//   match_over    high in MEND
//   match_winner  same encoding as round_winner, valid with match_over
//   state_dbg     IDLE=0 RRST=1 CDOWN=2 FIGHT=3 REND=4 MEND=5
// ---------------------------------------------------------------------------
module match_round_sequencer #(
  parameter int TICKS_PER_SEC  = 20,
  parameter int RESET_TICKS    = 2,
  parameter int COUNTDOWN_SEC  = 3,
  parameter int ROUND_TIME_SEC = 60,
  parameter int END_HOLD_TICKS = 40,
  parameter int WINS_NEEDED    = 2,
  parameter int MAX_ROUNDS     = 5,
  parameter int HEALTH_W       = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start_req,
  input  logic                ko_p1,
  input  logic                ko_p2,
  input  logic [HEALTH_W-1:0] health_p1,
  input  logic [HEALTH_W-1:0] health_p2,
  output logic                round_reset,
  output logic                input_enable,
  output logic [2:0]          round_num,
  output logic [1:0]          p1_wins,
  output logic [1:0]          p2_wins,
  output logic [3:0]          countdown,
  output logic [6:0]          round_time,
  output logic [1:0]          round_winner,
  output logic                match_over,
  output logic [1:0]          match_winner,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RRST  = 3'd1,
    S_CDOWN = 3'd2,
    S_FIGHT = 3'd3,
    S_REND  = 3'd4,
    S_MEND  = 3'd5
  } state_e;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  // One shared sub-second counter serves every timed state, so it must be
  // wide enough for the longest of the three tick windows.
  localparam int CNT_MAX_A = (TICKS_PER_SEC > RESET_TICKS) ? TICKS_PER_SEC : RESET_TICKS;
  localparam int CNT_MAX   = (CNT_MAX_A > END_HOLD_TICKS) ? CNT_MAX_A : END_HOLD_TICKS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SEC_LAST  = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(END_HOLD_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             start_prev_q, start_prev_d;
  logic             round_reset_q, round_reset_d;
  logic             input_enable_q, input_enable_d;
  logic [2:0]       round_num_q, round_num_d;
  logic [1:0]       p1_wins_q, p1_wins_d;
  logic [1:0]       p2_wins_q, p2_wins_d;
  logic [3:0]       countdown_q, countdown_d;
  logic [6:0]       round_time_q, round_time_d;
  logic [1:0]       round_winner_q, round_winner_d;
  logic             match_over_q, match_over_d;
  logic [1:0]       match_winner_q, match_winner_d;

  logic             start_edge;
  logic             sec_done;
  logic             time_out;
  logic             fight_end;
  logic [1:0]       fight_winner;

  assign start_edge = start_req & ~start_prev_q;
  assign sec_done   = (tick_cnt_q == SEC_LAST);
  // The last second expires on the tick that would take round_time to 0.
  assign time_out   = sec_done && (round_time_q == 7'd1);
  assign fight_end  = ko_p1 | ko_p2 | time_out;

  // KO outranks a time-out landing on the same tick.
  always_comb begin
    fight_winner = W_NONE;
    if (ko_p1 && ko_p2)          fight_winner = W_DRAW;
    else if (ko_p2)              fight_winner = W_P1;
    else if (ko_p1)              fight_winner = W_P2;
    else if (health_p1 > health_p2) fight_winner = W_P1;
    else if (health_p2 > health_p1) fight_winner = W_P2;
    else                         fight_winner = W_DRAW;
  end

  // NOTE: every next-state variable is given its hold value first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    start_prev_d   = start_req;
    round_reset_d  = round_reset_q;
    input_enable_d = input_enable_q;
    round_num_d    = round_num_q;
    p1_wins_d      = p1_wins_q;
    p2_wins_d      = p2_wins_q;
    countdown_d    = countdown_q;
    round_time_d   = round_time_q;
    round_winner_d = round_winner_q;
    match_over_d   = match_over_q;
    match_winner_d = match_winner_q;

    unique case (state_q)
      // IDLE and MEND share the new-match initialisation.
      S_IDLE, S_MEND: begin
        if (start_edge) begin
          state_d        = S_RRST;
          tick_cnt_d     = '0;
          round_reset_d  = 1'b1;
          round_num_d    = 3'd1;
          p1_wins_d      = 2'd0;
          p2_wins_d      = 2'd0;
          round_winner_d = W_NONE;
          match_over_d   = 1'b0;
          match_winner_d = W_NONE;
        end
      end

      S_RRST: begin
        if (tick) begin
          if (tick_cnt_q == RST_LAST) begin
            state_d       = S_CDOWN;
            tick_cnt_d    = '0;
            round_reset_d = 1'b0;
            countdown_d   = 4'(COUNTDOWN_SEC);
            round_time_d  = 7'(ROUND_TIME_SEC);
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_CDOWN: begin
        if (tick) begin
          if (sec_done) begin
            tick_cnt_d  = '0;
            countdown_d = countdown_q - 4'd1;
            if (countdown_q == 4'd1) begin
              state_d        = S_FIGHT;
              input_enable_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_FIGHT: begin
        if (tick) begin
          if (sec_done) begin
            tick_cnt_d   = '0;
            round_time_d = round_time_q - 7'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
          if (fight_end) begin
            state_d        = S_REND;
            tick_cnt_d     = '0;
            input_enable_d = 1'b0;
            round_winner_d = fight_winner;
            if (fight_winner == W_P1) p1_wins_d = p1_wins_q + 2'd1;
            if (fight_winner == W_P2) p2_wins_d = p2_wins_q + 2'd1;
          end
        end
      end

      S_REND: begin
        if (tick) begin
          if (tick_cnt_q == HOLD_LAST) begin
            tick_cnt_d = '0;
            if (p1_wins_q == 2'(WINS_NEEDED)) begin
              state_d        = S_MEND;
              match_over_d   = 1'b1;
              match_winner_d = W_P1;
            end else if (p2_wins_q == 2'(WINS_NEEDED)) begin
              state_d        = S_MEND;
              match_over_d   = 1'b1;
              match_winner_d = W_P2;
            end else if (round_num_q == 3'(MAX_ROUNDS)) begin
              state_d      = S_MEND;
              match_over_d = 1'b1;
              if (p1_wins_q > p2_wins_q)      match_winner_d = W_P1;
              else if (p2_wins_q > p1_wins_q) match_winner_d = W_P2;
              else                            match_winner_d = W_DRAW;
            end else begin
              state_d        = S_RRST;
              round_reset_d  = 1'b1;
              round_num_d    = round_num_q + 3'd1;
              round_winner_d = W_NONE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= '0;
      start_prev_q   <= 1'b0;
      round_reset_q  <= 1'b0;
      input_enable_q <= 1'b0;
      round_num_q    <= 3'd0;
      p1_wins_q      <= 2'd0;
      p2_wins_q      <= 2'd0;
      countdown_q    <= 4'd0;
      round_time_q   <= 7'd0;
      round_winner_q <= W_NONE;
      match_over_q   <= 1'b0;
      match_winner_q <= W_NONE;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      start_prev_q   <= start_prev_d;
      round_reset_q  <= round_reset_d;
      input_enable_q <= input_enable_d;
      round_num_q    <= round_num_d;
      p1_wins_q      <= p1_wins_d;
      p2_wins_q      <= p2_wins_d;
      countdown_q    <= countdown_d;
      round_time_q   <= round_time_d;
      round_winner_q <= round_winner_d;
      match_over_q   <= match_over_d;
      match_winner_q <= match_winner_d;
    end
  end

  assign round_reset  = round_reset_q;
  assign input_enable = input_enable_q;
  assign round_num    = round_num_q;
  assign p1_wins      = p1_wins_q;
  assign p2_wins      = p2_wins_q;
  assign countdown    = countdown_q;
  assign round_time   = round_time_q;
  assign round_winner = round_winner_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;
  assign state_dbg    = state_q;

endmodule
